gate_tt_checker: RTL and testbench

Sequential truth-table checker for the team's two-input combinational gate blocks. On a start pulse it drives the four input vectors A,B = 00, 01, 10, 11 into a gate under test and holds each for a fixed settle time. At the end of each hold it samples the gate's Y output and compares it with an expected truth table. It reports pass/fail, the mismatch count and the first failing vector, so gate blocks can be checked in hardware or self-checking benches without hand-written stimulus.

---
 rtl/gate_tt_checker.sv | 138 +++++++++++++
 tb/tb_gate_tt_checker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_checker.sv
// Sequential truth-table checker: drives A,B = 00..11 into a two-input gate, samples Y after SETTLE cycles per vector.
// Optional GATE_CHK_STOP_ON_FAIL_EN ends the run on the first mismatching vector.
module gate_tt_checker #(
    parameter logic [3:0] TRUTH  = 4'b1110,
    parameter int         SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Y,
    output logic       A,
    output logic       B,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] HCNT_LAST = 4'(SETTLE - 1);

    state_t     state_r, state_s;
    logic [1:0] vec_r, vec_s;
    logic [3:0] hcnt_r, hcnt_s;
    logic       a_s, b_s, busy_s, done_s;
    logic [2:0] err_s;
    logic [1:0] fail_s;
    logic       mismatch_s;
    logic       run_end_s;

    function automatic logic expected_y(input logic [1:0] ab);
        expected_y = TRUTH[ab];
    endfunction

    assign mismatch_s = (Y != expected_y({A, B}));

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    assign run_end_s = mismatch_s || (vec_r == 2'd3);
`else
    assign run_end_s = (vec_r == 2'd3);
`endif

    assign pass = done && (err_cnt == 3'd0);

    // Next-state and next-output decode.
    always_comb begin
        state_s = state_r;
        vec_s   = vec_r;
        hcnt_s  = hcnt_r;
        a_s     = A;
        b_s     = B;
        busy_s  = busy;
        done_s  = done;
        err_s   = err_cnt;
        fail_s  = fail_vec;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = HOLD;
                    vec_s   = 2'd0;
                    hcnt_s  = 4'd0;
                    a_s     = 1'b0;
                    b_s     = 1'b0;
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                    err_s   = 3'd0;
                    fail_s  = 2'd0;
                end else begin
                    state_s = state_r;
                end
            end
            HOLD: begin
                if (hcnt_r != HCNT_LAST) begin
                    hcnt_s = hcnt_r + 4'd1;
                end else begin
                    // Sample edge: the mismatch is counted before any DONE transition.
                    if (mismatch_s) begin
                        err_s = err_cnt + 3'd1;
                        if (err_cnt == 3'd0) begin
                            fail_s = {A, B};
                        end else begin
                            fail_s = fail_vec;
                        end
                    end else begin
                        err_s = err_cnt;
                    end
                    if (run_end_s) begin
                        state_s = DONE;
                        hcnt_s  = 4'd0;
                        a_s     = 1'b0;
                        b_s     = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        vec_s      = vec_r + 2'd1;
                        hcnt_s     = 4'd0;
                        {a_s, b_s} = vec_r + 2'd1;
                    end
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            vec_r    <= 2'd0;
            hcnt_r   <= 4'd0;
            A        <= 1'b0;
            B        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_cnt  <= 3'd0;
            fail_vec <= 2'd0;
        end else begin
            state_r  <= state_s;
            vec_r    <= vec_s;
            hcnt_r   <= hcnt_s;
            A        <= a_s;
            B        <= b_s;
            busy     <= busy_s;
            done     <= done_s;
            err_cnt  <= err_s;
            fail_vec <= fail_s;
        end
    end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Self-checking bench for gate_tt_checker: SETTLE=2 and SETTLE=1 instances against a cycle-count model.
module tb_gate_tt_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start2 = 1'b0;
    logic       start1 = 1'b0;
    int         mode = 0;
    logic       y2, a2, b2, busy2, done2, pass2;
    logic       y1, a1, b1, busy1, done1, pass1;
    logic [2:0] err2, err1;
    logic [1:0] fail2, fail1;
    int         checks = 0;
    int         errors = 0;

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    localparam int STUCK_BUSY = 4;
    localparam int STUCK_ERR  = 1;
    localparam int AND_BUSY   = 4;
    localparam int AND_ERR    = 1;
`else
    localparam int STUCK_BUSY = 8;
    localparam int STUCK_ERR  = 3;
    localparam int AND_BUSY   = 8;
    localparam int AND_ERR    = 2;
`endif

    always #5 clk = ~clk;

    // mode 0: good OR gate, 1: Y stuck at 0, other: AND gate
    function automatic logic gate_y(input int md, input logic [1:0] v);
        case (md)
            0:       gate_y = v[1] | v[0];
            1:       gate_y = 1'b0;
            default: gate_y = v[1] & v[0];
        endcase
    endfunction

    function automatic logic truth_bit(input int v);
        logic [3:0] tt;
        tt = 4'b1110;
        truth_bit = tt[v[1:0]];
    endfunction

    assign y2 = gate_y(mode, {a2, b2});
    assign y1 = gate_y(mode, {a1, b1});

    gate_tt_checker #(.TRUTH(4'b1110), .SETTLE(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .Y(y2), .A(a2), .B(b2),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_vec(fail2)
    );

    gate_tt_checker #(.TRUTH(4'b1110), .SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .Y(y1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fail1)
    );

    // Model: t counts cycles since the start edge; vector = t / S, sample when t % S == S-1.
    for (genvar k = 0; k < 2; k++) begin : g_model
        localparam int S = (k == 0) ? 2 : 1;
        logic       st;
        logic       run = 1'b0;
        logic       done = 1'b0;
        int         t = 0;
        int         err = 0;
        int         fail = 0;
        logic [9:0] exp;

        assign st = (k == 0) ? start2 : start1;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                run  <= 1'b0;
                done <= 1'b0;
                t    <= 0;
                err  <= 0;
                fail <= 0;
            end else if (run) begin
                if (t % S == S - 1) begin
                    if (gate_y(mode, 2'(t / S)) != truth_bit(t / S)) begin
                        err <= err + 1;
                        if (err == 0) fail <= t / S;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
                        run  <= 1'b0;
                        done <= 1'b1;
`endif
                    end
                    if (t / S == 3) begin
                        run  <= 1'b0;
                        done <= 1'b1;
                    end
                end
                t <= t + 1;
            end else if (st) begin
                run  <= 1'b1;
                t    <= 0;
                err  <= 0;
                fail <= 0;
                done <= 1'b0;
            end
        end

        assign exp = {run ? 2'(t / S) : 2'b00, run, done, done && (err == 0), 3'(err), 2'(fail)};
    end

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("dut2_cycle", {a2, b2, busy2, done2, pass2, err2, fail2}, g_model[0].exp);
        check("dut1_cycle", {a1, b1, busy1, done1, pass1, err1, fail1}, g_model[1].exp);
    end

    task automatic pulse(input int k);
        @(posedge clk);
        #1;
        if (k == 0) start2 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int k, input int extra_at, output int bc);
        logic fin;
        fin = 1'b0;
        bc  = 0;
        for (int i = 0; i < 60 && !fin; i++) begin
            @(negedge clk);
            if ((k == 0) ? busy2 : busy1) bc++;
            if ((k == 0) ? done2 : done1) fin = 1'b1;
            if (extra_at > 0) start2 = (bc == extra_at);
        end
        start2 = 1'b0;
        check("done_seen", {9'd0, fin}, 10'd1);
    endtask

    function automatic logic [9:0] res2();
        res2 = {3'd0, done2, pass2, err2, fail2};
    endfunction

    initial begin
        int   bc;
        logic found;

        @(posedge clk);
        #1;
        check("reset_dut2", {a2, b2, busy2, done2, pass2, err2, fail2}, 10'd0);
        check("reset_dut1", {a1, b1, busy1, done1, pass1, err1, fail1}, 10'd0);
        @(negedge clk);
        rst = 1'b0;

        mode = 0;
        pulse(0);
        wait_done(0, 0, bc);
        check("or_busy", 10'(bc), 10'd8);
        check("or_result", res2(), {3'd0, 1'b1, 1'b1, 3'd0, 2'd0});

        mode = 1;
        pulse(0);
        wait_done(0, 0, bc);
        check("stuck_busy", 10'(bc), 10'(STUCK_BUSY));
        check("stuck_result", res2(), {3'd0, 1'b1, 1'b0, 3'(STUCK_ERR), 2'd1});

        mode = 2;
        pulse(0);
        wait_done(0, 0, bc);
        check("and_busy", 10'(bc), 10'(AND_BUSY));
        check("and_result", res2(), {3'd0, 1'b1, 1'b0, 3'(AND_ERR), 2'd1});

        mode = 0;
        pulse(0);
        check("restart_clears", {5'd0, done2, busy2, err2}, {5'd0, 1'b0, 1'b1, 3'd0});
        wait_done(0, 3, bc);
        check("ignore_start_busy", 10'(bc), 10'd8);
        check("ignore_start_result", res2(), {3'd0, 1'b1, 1'b1, 3'd0, 2'd0});

        pulse(0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if ({a2, b2} == 2'b10) found = 1'b1;
        end
        check("reached_vec10", {9'd0, found}, 10'd1);
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", {a2, b2, busy2, done2, pass2, err2, fail2}, 10'd0);
        @(negedge clk);
        rst = 1'b0;
        pulse(0);
        wait_done(0, 0, bc);
        check("post_reset_busy", 10'(bc), 10'd8);
        check("post_reset_result", res2(), {3'd0, 1'b1, 1'b1, 3'd0, 2'd0});

        pulse(1);
        wait_done(1, 0, bc);
        check("settle1_busy", 10'(bc), 10'd4);
        check("settle1_result", {3'd0, done1, pass1, err1, fail1}, {3'd0, 1'b1, 1'b1, 3'd0, 2'd0});

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
